// File: rtl/data_mem_responder.sv
// Word-addressed data RAM behind the CPU load/store port: accepts one request,
// waits WAIT_CYCLES, then answers with a one-cycle ready carrying rdata or err.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  if (WAIT_CYCLES > 15) begin : g_bad_wait
    $error("data_mem_responder: WAIT_CYCLES must be 0..15");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        ready_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        busy_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic        acc_we_s;
  logic [31:0] acc_addr_s;
  logic [31:0] acc_wdata_s;
  logic [31:0] off_s;
  logic        fault_s;
  logic [AW-1:0] idx_s;
  logic        go_resp_s;
  logic        mem_wr_s;
  logic [31:0] rd_val_s;

  // With zero wait states RESP is entered on the accepting edge itself, so the
  // access must be evaluated on the live inputs while still in IDLE.
  assign acc_we_s    = (state_q == S_IDLE) ? we    : we_q;
  assign acc_addr_s  = (state_q == S_IDLE) ? addr  : addr_q;
  assign acc_wdata_s = (state_q == S_IDLE) ? wdata : wdata_q;

  assign off_s   = acc_addr_s - ADDR_BASE;
  assign fault_s = (acc_addr_s[1:0] != 2'b00) || (acc_addr_s < ADDR_BASE) ||
                   ((off_s >> 2) >= 32'(DEPTH_WORDS));
  assign idx_s   = off_s[AW+1:2];

  assign go_resp_s = ((state_q == S_IDLE) && req && (WAIT_CYCLES == 0)) ||
                     ((state_q == S_WAIT) && (cnt_q == 4'd0));
  assign mem_wr_s  = go_resp_s && acc_we_s && !fault_s && reset;
  assign rd_val_s  = (acc_we_s || fault_s) ? 32'h0 : mem_q[idx_s];

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_wr_s) begin
      mem_q[idx_s] <= acc_wdata_s;
    end
  end

  // Transaction FSM with registered Moore outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      ready_q <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b0;
          rdata_q <= 32'h0;
          err_q   <= 1'b0;
          if (req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            busy_q  <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state_q <= S_RESP;
              ready_q <= 1'b1;
              err_q   <= fault_s;
              rdata_q <= rd_val_s;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= 4'(WAIT_CYCLES - 1);
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_WAIT: begin
          busy_q <= 1'b1;
          if (cnt_q == 4'd0) begin
            state_q <= S_RESP;
            ready_q <= 1'b1;
            err_q   <= fault_s;
            rdata_q <= rd_val_s;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          rdata_q <= 32'h0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          rdata_q <= 32'h0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign rdata = rdata_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a WAIT_CYCLES=2 instance at base 0 and a
// WAIT_CYCLES=0 instance at a non-zero base, both checked against array models.
module tb_data_mem_responder;

  localparam int          W2 = 2;
  localparam logic [31:0] B0 = 32'h0000_1000;
  localparam int          D0 = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic req2 = 1'b0, we2 = 1'b0, ready2, err2, busy2;
  logic [31:0] addr2 = 32'h0, wdata2 = 32'h0, rdata2;
  logic req0 = 1'b0, we0 = 1'b0, ready0, err0, busy0;
  logic [31:0] addr0 = 32'h0, wdata0 = 32'h0, rdata0;

  int tests = 0;
  int fails = 0;

  logic [31:0] m2 [64];
  bit          v2 [64];
  logic [31:0] m0 [D0];
  bit          v0 [D0];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(W2), .ADDR_BASE(32'h0)) u_dut2 (
    .clk(clk), .reset(reset), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
    .ready(ready2), .rdata(rdata2), .err(err2), .busy(busy2));

  data_mem_responder #(.DEPTH_WORDS(D0), .WAIT_CYCLES(0), .ADDR_BASE(B0)) u_dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .ready(ready0), .rdata(rdata0), .err(err0), .busy(busy0));

  function automatic bit is_fault(input logic [31:0] a, input longint base, input longint depth);
    longint la;
    la = a;
    return (la % 4 != 0) || (la < base) || ((la - base) / 4 >= depth);
  endfunction

  // Drives one transaction on the WAIT_CYCLES=2 instance and reports what came back.
  task automatic run2(input logic w, input logic [31:0] a, input logic [31:0] d, input bit drop,
                      output int lat, output int width, output logic [31:0] rd,
                      output logic e, output logic b1);
    lat = -1; width = 0; rd = 32'h0; e = 1'b0; b1 = 1'b0;
    @(negedge clk);
    req2 = 1'b1; we2 = w; addr2 = a; wdata2 = d;
    @(posedge clk); #1;
    b1 = busy2;
    for (int k = 1; k <= 20; k++) begin
      if (ready2) begin
        if (lat < 0) begin lat = k; rd = rdata2; e = err2; end
        width++;
        req2 = 1'b0;
      end else if (lat >= 0) begin
        break;
      end
      if (drop || lat >= 0) begin
        req2 = 1'b0; addr2 = $urandom; wdata2 = $urandom; we2 = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    req2 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req2 = 1'b1; we2 = 1'b1; addr2 = 32'h4; wdata2 = 32'hFFFF_0000;
    req0 = 1'b1; we0 = 1'b1; addr0 = B0; wdata0 = 32'h1111_2222;
    repeat (3) begin
      @(posedge clk); #1;
      tests++;
      if ({ready2, busy2, err2, rdata2} !== {3'b000, 32'h0}) begin
        fails++; $display("FAIL reset_w2: got r=%b b=%b e=%b d=%h, want all 0", ready2, busy2, err2, rdata2);
      end
      tests++;
      if ({ready0, busy0, err0, rdata0} !== {3'b000, 32'h0}) begin
        fails++; $display("FAIL reset_w0: got r=%b b=%b e=%b d=%h, want all 0", ready0, busy0, err0, rdata0);
      end
    end
    @(negedge clk);
    req2 = 1'b0; req0 = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({busy2, busy0, ready2, ready0} !== 4'b0000) begin
      fails++; $display("FAIL reset_release_idle: got busy2=%b busy0=%b, want 0", busy2, busy0);
    end
  endtask

  task automatic test_store_load();
    int lat, width; logic [31:0] rd; logic e, b1;
    run2(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, lat, width, rd, e, b1);
    m2[4] = 32'hDEAD_BEEF; v2[4] = 1'b1;
    tests++;
    if (lat !== W2 + 1 || width !== 1 || e !== 1'b0 || rd !== 32'h0 || b1 !== 1'b1) begin
      fails++; $display("FAIL store_0x10: lat=%0d w=%0d err=%b rd=%h busy=%b, want lat=%0d w=1 err=0 rd=0 busy=1",
                        lat, width, e, rd, b1, W2 + 1);
    end
    run2(1'b0, 32'h10, 32'h0, 1'b0, lat, width, rd, e, b1);
    tests++;
    if (lat !== W2 + 1 || width !== 1 || e !== 1'b0 || rd !== m2[4]) begin
      fails++; $display("FAIL load_0x10: lat=%0d w=%0d err=%b rd=%h, want lat=%0d w=1 err=0 rd=%h",
                        lat, width, e, rd, W2 + 1, m2[4]);
    end
  endtask

  task automatic test_faults();
    int lat, width; logic [31:0] rd; logic e, b1;
    logic [31:0] a_list [4];
    a_list[0] = 32'h0; a_list[1] = 32'hFC; a_list[2] = 32'h12; a_list[3] = 32'h100;
    for (int i = 0; i < 2; i++) begin
      m2[a_list[i] >> 2] = $urandom; v2[a_list[i] >> 2] = 1'b1;
      run2(1'b1, a_list[i], m2[a_list[i] >> 2], 1'b0, lat, width, rd, e, b1);
    end
    run2(1'b0, 32'h12, 32'h0, 1'b0, lat, width, rd, e, b1);
    tests++;
    if (e !== 1'b1 || rd !== 32'h0 || lat !== W2 + 1) begin
      fails++; $display("FAIL misaligned_load: err=%b rd=%h lat=%0d, want err=1 rd=0 lat=%0d", e, rd, lat, W2 + 1);
    end
    run2(1'b1, 32'h100, 32'hCAFE_F00D, 1'b0, lat, width, rd, e, b1);
    tests++;
    if (e !== 1'b1 || rd !== 32'h0 || lat !== W2 + 1) begin
      fails++; $display("FAIL oob_store: err=%b rd=%h lat=%0d, want err=1 rd=0 lat=%0d", e, rd, lat, W2 + 1);
    end
    for (int i = 0; i < 2; i++) begin
      run2(1'b0, a_list[i], 32'h0, 1'b0, lat, width, rd, e, b1);
      tests++;
      if (e !== 1'b0 || rd !== m2[a_list[i] >> 2]) begin
        fails++; $display("FAIL edge_word_%h: err=%b rd=%h, want err=0 rd=%h", a_list[i], e, rd, m2[a_list[i] >> 2]);
      end
    end
  endtask

  task automatic test_req_drop();
    int lat, width; logic [31:0] rd; logic e, b1;
    run2(1'b1, 32'h20, 32'h1234_5678, 1'b1, lat, width, rd, e, b1);
    m2[8] = 32'h1234_5678; v2[8] = 1'b1;
    tests++;
    if (lat !== W2 + 1 || width !== 1 || e !== 1'b0) begin
      fails++; $display("FAIL drop_store: lat=%0d w=%0d err=%b, want lat=%0d w=1 err=0", lat, width, e, W2 + 1);
    end
    run2(1'b0, 32'h20, 32'h0, 1'b0, lat, width, rd, e, b1);
    tests++;
    if (rd !== 32'h1234_5678 || e !== 1'b0) begin
      fails++; $display("FAIL drop_load: rd=%h err=%b, want rd=12345678 err=0", rd, e);
    end
  endtask

  task automatic test_random();
    int lat, width; logic [31:0] rd; logic e, b1;
    logic w; logic [31:0] a, d; bit f;
    for (int i = 0; i < 24; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 32'h44)) * 32'd4;
      if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, 3));
      d = $urandom;
      f = is_fault(a, 0, 64);
      run2(w, a, d, 1'($urandom_range(0, 1)), lat, width, rd, e, b1);
      tests++;
      if (e !== f || lat !== W2 + 1 || width !== 1) begin
        fails++; $display("FAIL rand_%0d_ctl: a=%h err=%b lat=%0d w=%0d, want err=%b lat=%0d w=1", i, a, e, lat, width, f, W2 + 1);
      end
      if (w || f || v2[a >> 2]) begin
        tests++;
        if (rd !== ((w || f) ? 32'h0 : m2[a >> 2])) begin
          fails++; $display("FAIL rand_%0d_data: a=%h got %h want %h", i, a, rd, (w || f) ? 32'h0 : m2[a >> 2]);
        end
      end
      if (w && !f) begin m2[a >> 2] = d; v2[a >> 2] = 1'b1; end
    end
  endtask

  task automatic pick0(input int i, output logic w, output logic [31:0] a, output logic [31:0] d);
    d = $urandom;
    if (i < 4) begin
      w = 1'b1; a = B0 + 32'(4 * i);
    end else if (i == 5) begin
      w = 1'($urandom_range(0, 1)); a = B0 - 32'd4;
    end else if (i == 6) begin
      w = 1'b1; a = B0 + 32'(4 * D0);
    end else begin
      w = 1'b0; a = B0 + 32'(4 * $urandom_range(0, 3));
    end
  endtask

  task automatic test_back_to_back();
    logic w; logic [31:0] a, d; bit f;
    @(negedge clk);
    pick0(0, w, a, d);
    req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (c % 2 == 0) begin
        f = is_fault(a, B0, D0);
        tests++;
        if (ready0 !== 1'b1 || busy0 !== 1'b1 || err0 !== f ||
            rdata0 !== ((w || f) ? 32'h0 : m0[(a - B0) >> 2])) begin
          fails++; $display("FAIL b2b_resp_%0d: r=%b b=%b e=%b d=%h, want r=1 b=1 e=%b d=%h", c, ready0, busy0,
                            err0, rdata0, f, (w || f) ? 32'h0 : m0[(a - B0) >> 2]);
        end
        if (w && !f) begin m0[(a - B0) >> 2] = d; v0[(a - B0) >> 2] = 1'b1; end
        if (c < 14) begin
          pick0(c / 2 + 1, w, a, d);
          we0 = w; addr0 = a; wdata0 = d;
        end else begin
          req0 = 1'b0;
        end
      end else begin
        tests++;
        if (ready0 !== 1'b0 || busy0 !== 1'b0) begin
          fails++; $display("FAIL b2b_idle_%0d: r=%b b=%b, want r=0 b=0", c, ready0, busy0);
        end
      end
    end
    req0 = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    int lat, width; logic [31:0] rd; logic e, b1; bit seen;
    run2(1'b1, 32'h30, 32'h0, 1'b0, lat, width, rd, e, b1);
    m2[12] = 32'h0; v2[12] = 1'b1;
    @(negedge clk);
    req2 = 1'b1; we2 = 1'b1; addr2 = 32'h30; wdata2 = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    tests++;
    if (busy2 !== 1'b1) begin
      fails++; $display("FAIL midwait_busy: got %b want 1", busy2);
    end
    @(negedge clk);
    reset = 1'b0; req2 = 1'b0;
    #1;
    tests++;
    if ({ready2, busy2, err2, rdata2} !== {3'b000, 32'h0}) begin
      fails++; $display("FAIL midwait_async_clear: r=%b b=%b e=%b d=%h, want all 0", ready2, busy2, err2, rdata2);
    end
    seen = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (ready2) seen = 1'b1; end
    @(negedge clk);
    reset = 1'b1;
    repeat (4) begin @(posedge clk); #1; if (ready2 || busy2) seen = 1'b1; end
    tests++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL midwait_no_ready: got activity=1 want 0");
    end
    run2(1'b0, 32'h30, 32'h0, 1'b0, lat, width, rd, e, b1);
    tests++;
    if (rd !== m2[12] || e !== 1'b0 || lat !== W2 + 1) begin
      fails++; $display("FAIL midwait_load: rd=%h err=%b lat=%0d, want rd=%h err=0 lat=%0d", rd, e, lat, m2[12], W2 + 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) v2[i] = 1'b0;
    for (int i = 0; i < D0; i++) v0[i] = 1'b0;
    test_reset();
    test_store_load();
    test_faults();
    test_req_drop();
    test_random();
    test_back_to_back();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
